// File: rtl/module_display_bcd_scan.sv
// Two-digit multiplexed seven-segment scanner for a packed BCD byte.
// Alternates units/tens anodes with an all-off guard gap between digits.
module module_display_bcd_scan #(
  parameter int REFRESH_COUNT = 27000,
  parameter int GUARD         = 270,
  parameter int LZ_BLANK      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_i,
  input  logic       load_i,
  input  logic       en_i,
  output logic [6:0] seg_o,
  output logic [1:0] an_o,
  output logic       frame_tick_o
);

  localparam int CW = $clog2(REFRESH_COUNT);

  // Encoding order lets the state simply increment and wrap back to GAP_U.
  localparam logic [1:0] GAP_U  = 2'd0;
  localparam logic [1:0] SHOW_U = 2'd1;
  localparam logic [1:0] GAP_T  = 2'd2;
  localparam logic [1:0] SHOW_T = 2'd3;

  localparam logic [CW-1:0] GAP_LAST  = CW'(GUARD - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_COUNT - GUARD - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    data;
  logic          slot_last;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;

  function automatic logic [6:0] encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

  assign slot_last = (state == GAP_U || state == GAP_T) ? (cnt == GAP_LAST)
                                                        : (cnt == SHOW_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GAP_U;
      cnt   <= '0;
    end else if (slot_last) begin
      state <= state + 2'd1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= 8'h00;
    end else if (load_i) begin
      data <= bcd_i;
    end
  end

  // NOTE: defaults first so no path through the block leaves an output
  // unassigned, which would infer a latch.
  always_comb begin
    seg_next = SEG_OFF;
    an_next  = AN_OFF;
    case (state)
      SHOW_U: begin
        seg_next = encode(data[3:0]);
        an_next  = 2'b10;
      end
      SHOW_T: begin
        if (!(LZ_BLANK != 0 && data[7:4] == 4'd0)) begin
          seg_next = encode(data[7:4]);
          an_next  = 2'b01;
        end
      end
      default: ;
    endcase
    if (!en_i) an_next = AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_o        <= SEG_OFF;
      an_o         <= AN_OFF;
      frame_tick_o <= 1'b0;
    end else begin
      seg_o        <= seg_next;
      an_o         <= an_next;
      frame_tick_o <= (state == SHOW_T) && slot_last;
    end
  end

endmodule

// File: tb/tb_module_display_bcd_scan.sv
// Randomised bench for module_display_bcd_scan with a frame-position model:
// outputs are predicted from the cycle index modulo the frame length.
module tb_module_display_bcd_scan;

  localparam int RC    = 8;
  localparam int G     = 2;
  localparam int FRAME = 2 * RC;

  logic       clk = 1'b0;
  logic       rst, load_i, en_i;
  logic [7:0] bcd_i;
  logic [6:0] seg_lz, seg_nz;
  logic [1:0] an_lz, an_nz;
  logic       tick_lz, tick_nz;

  always #5 clk = ~clk;

  module_display_bcd_scan #(.REFRESH_COUNT(RC), .GUARD(G), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst(rst), .bcd_i(bcd_i), .load_i(load_i), .en_i(en_i),
    .seg_o(seg_lz), .an_o(an_lz), .frame_tick_o(tick_lz)
  );

  module_display_bcd_scan #(.REFRESH_COUNT(RC), .GUARD(G), .LZ_BLANK(0)) dut_nz (
    .clk(clk), .rst(rst), .bcd_i(bcd_i), .load_i(load_i), .en_i(en_i),
    .seg_o(seg_nz), .an_o(an_nz), .frame_tick_o(tick_nz)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: position within the frame and the displayed value.
  int         m_pos = 0;
  logic [7:0] m_data = 8'h00;
  bit         valid = 0;
  logic [6:0] exp_seg [2];
  logic [1:0] exp_an  [2];
  logic       exp_tick;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t pos=%0d)", tag, got, exp, $time, m_pos);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d > 4'd9) ? 7'b0111111 : tbl[d];
  endfunction

  task automatic step(input logic r, input logic ld, input logic [7:0] b, input logic e);
    @(negedge clk);
    if (valid) begin
      check("seg_lz", {1'b0, seg_lz}, {1'b0, exp_seg[0]});
      check("an_lz", {6'b0, an_lz}, {6'b0, exp_an[0]});
      check("seg_nz", {1'b0, seg_nz}, {1'b0, exp_seg[1]});
      check("an_nz", {6'b0, an_nz}, {6'b0, exp_an[1]});
      check("tick_lz", {7'b0, tick_lz}, {7'b0, exp_tick});
      check("tick_nz", {7'b0, tick_nz}, {7'b0, exp_tick});
      check("overlap", {7'b0, (an_lz == 2'b00) || (an_nz == 2'b00)}, 8'h00);
    end
    rst = r; load_i = ld; bcd_i = b; en_i = e;
    @(posedge clk);
    valid = 1;
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        exp_seg[k] = 7'h7F;
        exp_an[k]  = 2'b11;
      end
      exp_tick = 1'b0;
      m_pos    = 0;
      m_data   = 8'h00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_seg[k] = 7'h7F;
        exp_an[k]  = 2'b11;
        if (m_pos >= G && m_pos < RC) begin
          exp_seg[k] = enc(m_data[3:0]);
          exp_an[k]  = 2'b10;
        end else if (m_pos >= RC + G && !(k == 0 && m_data[7:4] == 4'd0)) begin
          exp_seg[k] = enc(m_data[7:4]);
          exp_an[k]  = 2'b01;
        end
        if (!e) exp_an[k] = 2'b11;
      end
      exp_tick = (m_pos == FRAME - 1);
      m_pos    = (m_pos + 1) % FRAME;
      if (ld) m_data = b;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic seek(input int lo, input int hi);
    for (int i = 0; i < FRAME && !(m_pos >= lo && m_pos <= hi); i++) idle(1);
  endtask

  initial begin
    rst = 1'b1; load_i = 1'b0; bcd_i = 8'h00; en_i = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
    idle(2 * FRAME + 2);

    step(1'b0, 1'b1, 8'h81, 1'b1); idle(FRAME + 4);
    step(1'b0, 1'b1, 8'h05, 1'b1); idle(FRAME + 4);
    step(1'b0, 1'b1, 8'h3C, 1'b1); idle(FRAME + 4);

    seek(G, RC - 2);
    step(1'b0, 1'b1, 8'h42, 1'b1); idle(FRAME);

    seek(RC + G + 1, RC + G + 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    idle(FRAME + 2);

    seek(RC + G + 3, RC + G + 3);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    idle(FRAME + 4);

    for (int i = 0; i < 400; i++) begin
      logic r, ld, e;
      logic [7:0] b;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 9) != 0);
      b  = 8'($urandom);
      step(r, ld, b, e);
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
